// File: rtl/hitspy_pkg.sv
// Shared constants for the hitspy transmit sequencer: state encoding,
// out_layer tags and the default word width.
package hitspy_pkg;

    localparam int DATA_W_DEF = 21;

    // The state names the word currently presented on out_data.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_L1   = 3'd1,
        ST_L2   = 3'd2,
        ST_L3   = 3'd3,
        ST_L4   = 3'd4,
        ST_L5   = 3'd5,
        ST_TRL  = 3'd6
    } state_t;

    // out_layer tags share the state encoding so a state can be copied straight into the tag.
    localparam logic [2:0] TAG_IDLE = 3'd0;
    localparam logic [2:0] TAG_L1   = 3'd1;
    localparam logic [2:0] TAG_L2   = 3'd2;
    localparam logic [2:0] TAG_L3   = 3'd3;
    localparam logic [2:0] TAG_L4   = 3'd4;
    localparam logic [2:0] TAG_L5   = 3'd5;
    localparam logic [2:0] TAG_TRL  = 3'd6;

endpackage

// File: rtl/hitspy_next_layer.sv
// Picks the next word to present: the lowest set hitmap layer strictly above
// cur_idx, or the trailer when no such layer remains. cur_idx = 0 gives the
// first word of a freshly accepted record.
module hitspy_next_layer
    import hitspy_pkg::*;
(
    input  logic [4:0] mask,
    input  logic [2:0] cur_idx,
    output logic [2:0] next_idx
);

    // Scan downwards so the last hit written is the lowest qualifying layer.
    always_comb begin
        next_idx = TAG_TRL;
        for (int k = 5; k >= 1; k--) begin
            if (mask[k-1] && (3'(k) > cur_idx)) begin
                next_idx = 3'(k);
            end
        end
    end

endmodule

// File: rtl/hitspy_control_out.sv
// Transmit-side sequencer: captures one parallel event record and streams its
// set layers in ascending order followed by the trailer, honouring downstream hold.
module hitspy_control_out
    import hitspy_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = 16
)
(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        hitmap,
    input  logic [DATA_W-1:0] hit1,
    input  logic [DATA_W-1:0] hit2,
    input  logic [DATA_W-1:0] hit3,
    input  logic [DATA_W-1:0] hit4,
    input  logic [DATA_W-1:0] hit5,
    input  logic [DATA_W-1:0] trailer,
    input  logic              hold,
    output logic [DATA_W-1:0] out_data,
    output logic              out_dv,
    output logic              out_ee,
    output logic [2:0]        out_layer,
    output logic              busy,
    output logic [CNT_W-1:0]  evt_count
);

    state_t            state;
    logic [4:0]        buf_hitmap;
    logic [DATA_W-1:0] buf_hit1;
    logic [DATA_W-1:0] buf_hit2;
    logic [DATA_W-1:0] buf_hit3;
    logic [DATA_W-1:0] buf_hit4;
    logic [DATA_W-1:0] buf_hit5;
    logic [DATA_W-1:0] buf_trailer;

    logic [2:0]        acc_next;
    logic [2:0]        adv_next;
    logic              trl_done;
    logic              accept;

    // Word selector shared by the accept path (live inputs) and the advance path (buffer).
    function automatic logic [DATA_W-1:0] word_for(
        input logic [2:0]        idx,
        input logic [DATA_W-1:0] w1,
        input logic [DATA_W-1:0] w2,
        input logic [DATA_W-1:0] w3,
        input logic [DATA_W-1:0] w4,
        input logic [DATA_W-1:0] w5,
        input logic [DATA_W-1:0] wt
    );
        logic [DATA_W-1:0] w;
        case (idx)
            TAG_L1:  w = w1;
            TAG_L2:  w = w2;
            TAG_L3:  w = w3;
            TAG_L4:  w = w4;
            TAG_L5:  w = w5;
            default: w = wt;
        endcase
        return w;
    endfunction

    hitspy_next_layer u_next_accept (
        .mask     (hitmap),
        .cur_idx  (TAG_IDLE),
        .next_idx (acc_next)
    );

    hitspy_next_layer u_next_advance (
        .mask     (buf_hitmap),
        .cur_idx  (state),
        .next_idx (adv_next)
    );

    // Handshake: the trailer transfer frees the buffer in the same cycle, allowing back-to-back events.
    assign trl_done = (state == ST_TRL) && !hold;
    assign in_ready = (state == ST_IDLE) || trl_done;
    assign accept   = in_valid && in_ready;
    assign out_dv   = (state != ST_IDLE) && !hold;
    assign busy     = (state != ST_IDLE);

    // Sequencer: outputs are loaded with the word for the state being entered, frozen while held.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_IDLE;
            out_data    <= '0;
            out_layer   <= TAG_IDLE;
            out_ee      <= 1'b0;
            evt_count   <= '0;
            buf_hitmap  <= '0;
            buf_hit1    <= '0;
            buf_hit2    <= '0;
            buf_hit3    <= '0;
            buf_hit4    <= '0;
            buf_hit5    <= '0;
            buf_trailer <= '0;
        end else begin
            if (trl_done) begin
                evt_count <= evt_count + 1'b1;
            end

            if (accept) begin
                buf_hitmap  <= hitmap;
                buf_hit1    <= hit1;
                buf_hit2    <= hit2;
                buf_hit3    <= hit3;
                buf_hit4    <= hit4;
                buf_hit5    <= hit5;
                buf_trailer <= trailer;
                state       <= state_t'(acc_next);
                out_data    <= word_for(acc_next, hit1, hit2, hit3, hit4, hit5, trailer);
                out_layer   <= acc_next;
                out_ee      <= (acc_next == TAG_TRL);
            end else if (trl_done) begin
                // out_data keeps the trailer so the idle bus does not toggle.
                state     <= ST_IDLE;
                out_layer <= TAG_IDLE;
                out_ee    <= 1'b0;
            end else if ((state != ST_IDLE) && (state != ST_TRL) && !hold) begin
                state     <= state_t'(adv_next);
                out_data  <= word_for(adv_next, buf_hit1, buf_hit2, buf_hit3,
                                      buf_hit4, buf_hit5, buf_trailer);
                out_layer <= adv_next;
                out_ee    <= (adv_next == TAG_TRL);
            end
        end
    end

endmodule

// File: tb/tb_hitspy_control_out.sv
// Randomized and directed bench for hitspy_control_out. A queue holds the words
// each accepted record must still emit; handshake and status expectations are
// derived from the queue occupancy and the hold input.
module tb_hitspy_control_out;

    localparam int DW = 21;
    localparam int CW = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [2:0]    layer;
    } exp_word_t;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    hitmap;
    logic [DW-1:0] hit1, hit2, hit3, hit4, hit5, trailer;
    logic          hold;
    logic [DW-1:0] out_data;
    logic          out_dv;
    logic          out_ee;
    logic [2:0]    out_layer;
    logic          busy;
    logic [CW-1:0] evt_count;

    exp_word_t     q[$];
    logic [CW-1:0] exp_evt;
    logic          after_rst;
    int            checks = 0;
    int            errors = 0;

    hitspy_control_out #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .hitmap    (hitmap),
        .hit1      (hit1),
        .hit2      (hit2),
        .hit3      (hit3),
        .hit4      (hit4),
        .hit5      (hit5),
        .trailer   (trailer),
        .hold      (hold),
        .out_data  (out_data),
        .out_dv    (out_dv),
        .out_ee    (out_ee),
        .out_layer (out_layer),
        .busy      (busy),
        .evt_count (evt_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_rec(input logic [4:0] hm, input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                           input logic [DW-1:0] w3, input logic [DW-1:0] w4,
                           input logic [DW-1:0] w5, input logic [DW-1:0] wt);
        hitmap = hm; hit1 = w1; hit2 = w2; hit3 = w3; hit4 = w4; hit5 = w5; trailer = wt;
    endtask

    // Expand the record on the inputs into the words it must produce.
    task automatic push_record();
        logic [DW-1:0] w [1:5];
        w[1] = hit1; w[2] = hit2; w[3] = hit3; w[4] = hit4; w[5] = hit5;
        for (int k = 1; k <= 5; k++) begin
            if (hitmap[k-1]) q.push_back('{data: w[k], layer: 3'(k)});
        end
        q.push_back('{data: trailer, layer: 3'd6});
    endtask

    // Called at a falling edge with inputs already driven: check, update model, advance one cycle.
    task automatic tick();
        logic      exp_busy, exp_ready, exp_dv;
        exp_word_t f;
        #1;
        exp_busy  = (q.size() != 0);
        exp_ready = (q.size() == 0) || ((q.size() == 1) && !hold);
        exp_dv    = exp_busy && !hold;
        check("busy", 32'(busy), 32'(exp_busy));
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        check("out_dv", 32'(out_dv), 32'(exp_dv));
        check("evt_count", 32'(evt_count), 32'(exp_evt));
        if (exp_busy) begin
            f = q[0];
            check("out_data", 32'(out_data), 32'(f.data));
            check("out_layer", 32'(out_layer), 32'(f.layer));
            check("out_ee", 32'(out_ee), 32'(f.layer == 3'd6));
        end else begin
            check("idle_layer", 32'(out_layer), 32'd0);
            check("idle_ee", 32'(out_ee), 32'd0);
            if (after_rst) check("rst_data", 32'(out_data), 32'd0);
        end
        after_rst = reset;
        if (reset) begin
            q.delete();
            exp_evt = '0;
        end else begin
            if (exp_dv) begin
                f = q.pop_front();
                if (f.layer == 3'd6) exp_evt = exp_evt + 1'b1;
            end
            if (in_valid && exp_ready) push_record();
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; hold = 1'b0;
        set_rec(5'b0, '0, '0, '0, '0, '0, '0);
        exp_evt = '0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        after_rst = 1'b1;
        run(2);

        // Sparse hitmap: 1, 3, 5, trailer.
        set_rec(5'b10101, 21'd1, 21'd2, 21'd3, 21'd4, 21'd5, 21'h7F);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; set_rec(5'b11111, '1, '1, '1, '1, '1, '1);
        run(6);

        // Empty hitmap: trailer only.
        set_rec(5'b00000, 21'h11, 21'h12, 21'h13, 21'h14, 21'h15, 21'h1ABCD);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; run(3);

        // Back-to-back records: full then layer 2 only.
        set_rec(5'h1F, 21'h101, 21'h102, 21'h103, 21'h104, 21'h105, 21'h1F0);
        in_valid = 1'b1; tick();
        set_rec(5'b00010, 21'h201, 21'h202, 21'h203, 21'h204, 21'h205, 21'h2F0);
        run(6);
        in_valid = 1'b0; run(4);

        // Hold for three cycles while L3 is presented.
        set_rec(5'h1F, 21'h301, 21'h302, 21'h303, 21'h304, 21'h305, 21'h3F0);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; run(2);
        hold = 1'b1; run(3);
        hold = 1'b0; run(6);

        // Hold during the trailer with the next record waiting.
        set_rec(5'b00001, 21'h401, 21'h402, 21'h403, 21'h404, 21'h405, 21'h4F0);
        in_valid = 1'b1; tick();
        set_rec(5'b01000, 21'h501, 21'h502, 21'h503, 21'h504, 21'h505, 21'h5F0);
        tick();
        hold = 1'b1; run(2);
        hold = 1'b0; tick();
        in_valid = 1'b0; run(3);

        // Reset while L2 is presented, then a clean record.
        set_rec(5'h1F, 21'h601, 21'h602, 21'h603, 21'h604, 21'h605, 21'h6F0);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; tick();
        reset = 1'b1; tick();
        reset = 1'b0; tick();
        set_rec(5'b00100, 21'h701, 21'h702, 21'h703, 21'h704, 21'h705, 21'h7F0);
        in_valid = 1'b1; tick();
        in_valid = 1'b0; run(3);

        // Random traffic: inputs churn every cycle so unaccepted values must be ignored.
        for (int i = 0; i < 600; i++) begin
            reset    = ($urandom_range(0, 99) == 0);
            in_valid = ($urandom_range(0, 1) == 1);
            hold     = ($urandom_range(0, 3) == 0);
            set_rec(5'($urandom), DW'($urandom), DW'($urandom), DW'($urandom),
                    DW'($urandom), DW'($urandom), DW'($urandom));
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; hold = 1'b0;
        run(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
